seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstN, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port inValid, input, 1: request present.
REQ-005 SHALL have port inReady, output, 1: divider can accept a request.
REQ-006 SHALL have port signedOp, input, 1: high means operands are two's complement, low means unsigned.
REQ-007 SHALL have port dIn0, input, NUM_SIZE: dividend.
REQ-008 SHALL have port dIn1, input, NUM_SIZE: divisor.
REQ-009 SHALL have port outValid, output, 1: result present.
REQ-010 SHALL have port outReady, input, 1: consumer accepts the result.
REQ-011 SHALL have port quotient, output, NUM_SIZE.
REQ-012 SHALL have port remainder, output, NUM_SIZE.
REQ-013 SHALL have port divByZero, output, 1: result came from a zero divisor.

Function
REQ-014 SHALL implement states IDLE, BUSY and DONE: IDLE->BUSY on accept; BUSY->DONE when the step counter reaches NUM_SIZE; DONE->IDLE when outValid&&outReady.
REQ-015 SHALL assert inReady only in IDLE; a request is accepted when inValid&&inReady, and operands plus signedOp are captured on that edge.
REQ-016 SHALL perform one restoring step per BUSY cycle: shift the partial remainder left, bring in the next dividend bit (MSB first), trial-subtract the divisor magnitude, keep the result if non-negative and set the quotient bit to 1, else restore and set it to 0.
REQ-017 SHALL give latency of exactly NUM_SIZE+1 cycles from the accept edge to the first cycle outValid is high, independent of operand values.
REQ-018 SHALL, when signedOp is set, divide the magnitudes; the quotient is negated when the operand signs differ, and the remainder takes the dividend's sign (truncating division).
REQ-019 SHALL, for a zero divisor, produce quotient all-ones, remainder equal to dIn0 and divByZero=1, with the same latency as REQ-017.
REQ-020 SHALL, for signed overflow (dIn0 = most negative value, dIn1 = -1), produce quotient = dIn0 and remainder 0, with divByZero=0.
REQ-021 SHALL hold quotient, remainder and divByZero stable while outValid is high and outReady is low.
REQ-022 SHALL ignore inValid outside IDLE; there is no pipelining and at most one request is in flight.
REQ-023 SHALL NOT accept a new request in the cycle a result is consumed; acceptance resumes the following cycle in IDLE.

Reset
REQ-024 SHALL, while rstN is low, force state IDLE, the step counter to 0, inReady=1, outValid=0, quotient=0, remainder=0 and divByZero=0.
REQ-025 SHALL discard an in-progress operation (BUSY or DONE) when rstN is asserted, with no result emitted after release.
REQ-026 SHALL accept its first request on the first rising clk edge after rstN deasserts.

Structure
REQ-027 SHALL place the state encoding (IDLE, BUSY, DONE) and the step-counter width constant ($clog2(NUM_SIZE+1)) in a shared package, alongside the team's existing arithmetic constants.
REQ-028 SHALL instantiate exactly one sub-module, div_step: combinational, performing one shift/trial-subtract/select step and returning the next partial remainder and the quotient bit.
REQ-029 SHALL keep sign fix-up and special-case selection in the top module, applied on the BUSY->DONE transition.

Verification
REQ-030 SHALL verify unsigned division: DIVU 100/7 -> outValid after 33 cycles, quotient=14, remainder=2, divByZero=0.
REQ-031 SHALL verify signed division: -100/7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE); 100/-7 -> quotient=-14, remainder=2.
REQ-032 SHALL verify the zero divisor: 0x12345678/0 (either signedness) -> quotient=0xFFFFFFFF, remainder=0x12345678, divByZero=1, latency 33.
REQ-033 SHALL verify signed overflow: 0x80000000/0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
REQ-034 SHALL verify backpressure and lockout: hold outReady low 10 cycles -> outputs stable and inReady low; a new inValid during BUSY is ignored; after the consume, the next request is accepted one cycle later.
REQ-035 SHALL verify reset mid-operation: assert rstN low during BUSY step 16 -> outputs at reset values immediately; no outValid after release; a following 9/3 request returns quotient=3, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic constants and types for the sequential divider family.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Step counter must be able to hold the value n itself, not just n-1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, divisor_i});
  // A successful trial always leaves a result below the divisor, so W bits suffice.
  assign rem_o   = q_o ? W'(shifted - {1'b0, divisor_i}) : shifted[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed/unsigned, one quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int NUM_SIZE = DIV_WIDTH
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                inValid,
  output logic                inReady,
  input  logic                signedOp,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder,
  output logic                divByZero
);

  localparam int CNT_W = cnt_width(NUM_SIZE);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SIZE-1:0] prem_q, prem_d;    // partial remainder (magnitude)
  logic [NUM_SIZE-1:0] quo_q, quo_d;      // dividend bits out, quotient bits in
  logic [NUM_SIZE-1:0] dvs_q, dvs_d;      // divisor magnitude
  logic [NUM_SIZE-1:0] dvd_q, dvd_d;      // original dividend for the zero case
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                zero_q, zero_d;
  logic [NUM_SIZE-1:0] quot_out_q, quot_out_d;
  logic [NUM_SIZE-1:0] rem_out_q, rem_out_d;
  logic                dbz_q, dbz_d;

  logic                a_neg, b_neg;
  logic [NUM_SIZE-1:0] step_rem;
  logic                step_q;

  assign a_neg = signedOp & dIn0[NUM_SIZE-1];
  assign b_neg = signedOp & dIn1[NUM_SIZE-1];

  div_step #(.W(NUM_SIZE)) u_step (
    .rem_i     (prem_q),
    .bit_i     (quo_q[NUM_SIZE-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign inReady   = (state_q == IDLE);
  assign outValid  = (state_q == DONE);
  assign quotient  = quot_out_q;
  assign remainder = rem_out_q;
  assign divByZero = dbz_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    zero_d     = zero_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          state_d = BUSY;
          cnt_d   = '0;
          prem_d  = '0;
          quo_d   = a_neg ? -dIn0 : dIn0;
          dvs_d   = b_neg ? -dIn1 : dIn1;
          dvd_d   = dIn0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          zero_d  = (dIn1 == '0);
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(NUM_SIZE)) begin
          state_d = DONE;
          // Sign fix-up; the overflow case falls out naturally since -MIN == MIN.
          if (zero_q) begin
            quot_out_d = '1;
            rem_out_d  = dvd_q;
            dbz_d      = 1'b1;
          end else begin
            quot_out_d = qneg_q ? -quo_q : quo_q;
            rem_out_d  = rneg_q ? -prem_q : prem_q;
            dbz_d      = 1'b0;
          end
        end else begin
          prem_d = step_rem;
          quo_d  = {quo_q[NUM_SIZE-2:0], step_q};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dvd_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      zero_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      zero_q     <= zero_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with hand-computed expected results.
module tb_seq_divider;

  localparam int LAT      = 33;
  localparam int WAIT_MAX = 100;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic        signedOp;
  logic [31:0] dIn0;
  logic [31:0] dIn1;
  logic        outValid;
  logic        outReady;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.NUM_SIZE(32)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .inValid   (inValid),
    .inReady   (inReady),
    .signedOp  (signedOp),
    .dIn0      (dIn0),
    .dIn1      (dIn1),
    .outValid  (outValid),
    .outReady  (outReady),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  // Issues one request (inReady assumed high), waits for the result, consumes it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic z, output int lat);
    inValid = 1'b1; dIn0 = a; dIn1 = b; signedOp = s;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < WAIT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder; z = divByZero;
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; signedOp = 1'b0; dIn0 = '0; dIn1 = '0; outReady = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake inReady=%b outValid=%b want 1/0", inReady, outValid);
    end
    checks++;
    if (quotient !== 32'h0 || remainder !== 32'h0 || divByZero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs q=%h r=%h z=%b want 0/0/0", quotient, remainder, divByZero);
    end
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic z; int lat;
    run_op(32'd100, 32'd7, 1'b0, q, r, z, lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL divu_latency got=%0d want=%0d", lat, LAT); end
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      failures++; $display("FAIL divu_100_7 got q=%h r=%h z=%b want 0000000e/00000002/0", q, r, z);
    end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'h0 || z !== 1'b0) begin
      failures++; $display("FAIL divu_max_1 got q=%h r=%h z=%b want ffffffff/00000000/0", q, r, z);
    end
    run_op(32'd7, 32'd100, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 32'h0 || r !== 32'd7) begin
      failures++; $display("FAIL divu_7_100 got q=%h r=%h want 00000000/00000007", q, r);
    end
    run_op(32'hFFFF_FF9C, 32'd7, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 32'h2492_4916 || r !== 32'd2) begin
      failures++; $display("FAIL divu_big got q=%h r=%h want 24924916/00000002", q, r);
    end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic z; int lat;
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, q, r, z, lat);
    checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || z !== 1'b0) begin
      failures++; $display("FAIL divs_m100_7 got q=%h r=%h z=%b want fffffff2/fffffffe/0", q, r, z);
    end
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, q, r, z, lat);
    checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'd2) begin
      failures++; $display("FAIL divs_100_m7 got q=%h r=%h want fffffff2/00000002", q, r);
    end
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, q, r, z, lat);
    checks++;
    if (q !== 32'd14 || r !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL divs_m100_m7 got q=%h r=%h want 0000000e/fffffffe", q, r);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic z; int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(32'h1234_5678, 32'h0, s[0], q, r, z, lat);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678 || z !== 1'b1 || lat !== LAT) begin
        failures++;
        $display("FAIL divzero_s%0d got q=%h r=%h z=%b lat=%0d want ffffffff/12345678/1/%0d",
                 s, q, r, z, lat, LAT);
      end
    end
    run_op(32'h8000_0001, 32'h0, 1'b1, q, r, z, lat);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'h8000_0001 || z !== 1'b1) begin
      failures++; $display("FAIL divzero_neg got q=%h r=%h z=%b want ffffffff/80000001/1", q, r, z);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic z; int lat;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, z, lat);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'h0 || z !== 1'b0) begin
      failures++; $display("FAIL overflow got q=%h r=%h z=%b want 80000000/00000000/0", q, r, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    inValid = 1'b1; dIn0 = 32'd1000; dIn1 = 32'd10; signedOp = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (inReady !== 1'b0) begin failures++; $display("FAIL busy_inready got=%b want=0", inReady); end
    // Intruding request while busy must not disturb the running operation.
    inValid = 1'b1; dIn0 = 32'd77; dIn1 = 32'd0; signedOp = 1'b1;
    repeat (3) @(posedge clk);
    #1 inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < WAIT_MAX) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!outValid) begin failures++; $display("FAIL bp_timeout got outValid=0 want 1"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (quotient !== 32'd100 || remainder !== 32'h0 || divByZero !== 1'b0 ||
          outValid !== 1'b1 || inReady !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    // Consume with a new request already waiting: it must be taken one cycle later.
    outReady = 1'b1; inValid = 1'b1; dIn0 = 32'd50; dIn1 = 32'd5; signedOp = 1'b0;
    @(posedge clk); #1;
    outReady = 1'b0;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      failures++; $display("FAIL lockout got inReady=%b outValid=%b want 1/0", inReady, outValid);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    checks++;
    if (inReady !== 1'b0) begin failures++; $display("FAIL next_accept got inReady=%b want 0", inReady); end
    lat = 0;
    while (!outValid && lat < WAIT_MAX) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== LAT || quotient !== 32'd10 || remainder !== 32'h0) begin
      failures++;
      $display("FAIL b2b_result got q=%h r=%h lat=%0d want 0000000a/00000000/%0d",
               quotient, remainder, lat, LAT);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    bad = 0;
    repeat (40) begin @(posedge clk); #1; if (outValid) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL no_extra_result got %0d cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; logic z; int lat;
    int bad;
    inValid = 1'b1; dIn0 = 32'd1000; dIn1 = 32'd10; signedOp = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (16) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || quotient !== 32'h0 ||
        remainder !== 32'h0 || divByZero !== 1'b0) begin
      failures++;
      $display("FAIL midreset got rdy=%b vld=%b q=%h r=%h z=%b want 1/0/0/0/0",
               inReady, outValid, quotient, remainder, divByZero);
    end
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    bad = 0;
    repeat (40) begin @(posedge clk); #1; if (outValid) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midreset_ghost got %0d cycles want 0", bad); end
    run_op(32'd9, 32'd3, 1'b0, q, r, z, lat);
    checks++;
    if (q !== 32'd3 || r !== 32'h0 || lat !== LAT) begin
      failures++; $display("FAIL post_reset got q=%h r=%h lat=%0d want 3/0/%0d", q, r, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
